// File: rtl/frame_update_scheduler_pkg.sv
// Shared constants for the frame update scheduler: FSM state encodings,
// default sizing and the saturating overrun counter helper.
package frame_update_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } state_t;

    localparam int DEFAULT_NUM_CLIENTS    = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 65535;
    localparam int OVR_W                  = 8;

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (v == '1) ? v : v + OVR_W'(1);
    endfunction

endpackage

// File: rtl/frame_update_scheduler_grant_timer.sv
// Grant-length counter: cleared when a grant starts, counts while granted,
// flags the last permitted cycle of a grant.
module frame_update_scheduler_grant_timer #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TMR_W          = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMR_W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + TMR_W'(1);
        end
    end

    assign expired = (count_reg == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/frame_update_scheduler.sv
// Per-frame update sequencer: latches pending requests on a frame tick and
// grants the shared update slot to each pending client in index order.
module frame_update_scheduler
    import frame_update_scheduler_pkg::*;
#(
    parameter int NUM_CLIENTS    = DEFAULT_NUM_CLIENTS,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TMR_W          = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tick,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [NUM_CLIENTS-1:0] done,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic [ID_W-1:0]        active_id,
    output logic                   frame_start,
    output logic                   busy,
    output logic                   timeout,
    output logic                   overrun,
    output logic [OVR_W-1:0]       overrun_count
);

    state_t                 state_reg;
    logic [NUM_CLIENTS-1:0] pending_reg;
    logic [NUM_CLIENTS-1:0] grant_reg;
    logic [ID_W-1:0]        active_id_reg;
    logic                   frame_start_reg;
    logic                   busy_reg;
    logic                   timeout_reg;
    logic                   overrun_reg;
    logic [OVR_W-1:0]       overrun_count_reg;

    logic [NUM_CLIENTS-1:0] sel;
    logic                   cur_pending;
    logic                   cur_done;
    logic                   last_idx;
    logic                   timer_expired;
    logic                   release_now;
    logic                   tick_rejected;

    // One-hot decode of the index under examination; keeps all per-client
    // selection free of variable part-selects.
    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_sel
            assign sel[gi] = (active_id_reg == ID_W'(gi));
        end
    endgenerate

    assign cur_pending   = |(pending_reg & sel);
    assign cur_done      = |(done & sel);
    assign last_idx      = (active_id_reg == ID_W'(NUM_CLIENTS - 1));
    assign release_now   = (state_reg == GRANT) && (cur_done || timer_expired);
    assign tick_rejected = tick && (state_reg != IDLE);

    frame_update_scheduler_grant_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_grant_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   ((state_reg == SCAN) && cur_pending),
        .enable  (state_reg == GRANT),
        .expired (timer_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= IDLE;
            pending_reg       <= '0;
            grant_reg         <= '0;
            active_id_reg     <= '0;
            frame_start_reg   <= 1'b0;
            busy_reg          <= 1'b0;
            timeout_reg       <= 1'b0;
            overrun_reg       <= 1'b0;
            overrun_count_reg <= '0;
        end else begin
            frame_start_reg <= 1'b0;
            timeout_reg     <= 1'b0;
            overrun_reg     <= tick_rejected;
            if (tick_rejected) begin
                overrun_count_reg <= sat_inc(overrun_count_reg);
            end

            // busy stays up for one cycle after returning to IDLE
            case (state_reg)
                IDLE: begin
                    busy_reg      <= tick;
                    active_id_reg <= '0;
                    if (tick) begin
                        pending_reg     <= req;
                        frame_start_reg <= 1'b1;
                        state_reg       <= SCAN;
                    end
                end
                SCAN: begin
                    busy_reg <= 1'b1;
                    if (cur_pending) begin
                        grant_reg <= sel;
                        state_reg <= GRANT;
                    end else if (last_idx) begin
                        active_id_reg <= '0;
                        state_reg     <= IDLE;
                    end else begin
                        active_id_reg <= active_id_reg + ID_W'(1);
                    end
                end
                GRANT: begin
                    busy_reg <= 1'b1;
                    if (release_now) begin
                        grant_reg   <= '0;
                        pending_reg <= pending_reg & ~sel;
                        timeout_reg <= !cur_done;
                        if (last_idx) begin
                            active_id_reg <= '0;
                            state_reg     <= IDLE;
                        end else begin
                            active_id_reg <= active_id_reg + ID_W'(1);
                            state_reg     <= SCAN;
                        end
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    grant_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign grant         = grant_reg;
    assign active_id     = active_id_reg;
    assign frame_start   = frame_start_reg;
    assign busy          = busy_reg;
    assign timeout       = timeout_reg;
    assign overrun       = overrun_reg;
    assign overrun_count = overrun_count_reg;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Scenario bench for frame_update_scheduler: a grant scoreboard checks each
// new grant's value and cycle, scenario tasks check the remaining outputs.
module tb_frame_update_scheduler;

    localparam int NC  = 4;
    localparam int TO  = 8;

    typedef struct {
        logic [NC-1:0] g;
        int            c;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tick  = 1'b0;
    logic [NC-1:0] req   = '0;
    logic [NC-1:0] done  = '0;
    logic [NC-1:0] grant;
    logic [1:0]    active_id;
    logic          frame_start, busy, timeout, overrun;
    logic [7:0]    overrun_count;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    logic [NC-1:0] prev_grant = '0;

    frame_update_scheduler #(
        .NUM_CLIENTS    (NC),
        .ID_W           (2),
        .TIMEOUT_CYCLES (TO),
        .TMR_W          (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .tick          (tick),
        .req           (req),
        .done          (done),
        .grant         (grant),
        .active_id     (active_id),
        .frame_start   (frame_start),
        .busy          (busy),
        .timeout       (timeout),
        .overrun       (overrun),
        .overrun_count (overrun_count)
    );

    always #10 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every new nonzero grant must match the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (grant !== prev_grant && grant !== '0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_grant: got %b at cycle %0d, none expected", grant, cyc);
            end else begin
                e = exp_q.pop_front();
                if (grant !== e.g || cyc != e.c) begin
                    bad++;
                    $display("FAIL grant_seq: got %b at cycle %0d, expected %b at cycle %0d",
                             grant, cyc, e.g, e.c);
                end else begin
                    $display("grant %b at cycle %0d ok", grant, cyc);
                end
            end
        end
        prev_grant = grant;
    end

    task automatic wait_grant(input logic [NC-1:0] g, input string name);
        for (int k = 0; k < 30 && grant !== g; k++) @(negedge clock);
        total++;
        if (grant !== g) begin
            bad++;
            $display("FAIL %s: grant=%b, expected %b within 30 cycles", name, grant, g);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 40 && busy !== 1'b0; k++) @(negedge clock);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: busy=%b, expected 0 within 40 cycles", name, busy);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d grants still expected, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        total++;
        if ({grant, active_id, frame_start, busy, timeout, overrun, overrun_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: grant=%b id=%0d fs=%b busy=%b to=%b ov=%b cnt=%0d, required all 0",
                     grant, active_id, frame_start, busy, timeout, overrun, overrun_count);
        end
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic;
        int t0, d;
        req = 4'b1010; tick = 1'b1; t0 = cyc;
        exp_q.push_back('{4'b0010, t0 + 3});
        @(negedge clock);
        tick = 1'b0; req = '0;
        total++;
        if (frame_start !== 1'b1 || busy !== 1'b1 || active_id !== 2'd0) begin
            bad++;
            $display("FAIL basic_start: fs=%b busy=%b id=%0d, required 1 1 0", frame_start, busy, active_id);
        end
        @(negedge clock);
        total++;
        if (frame_start !== 1'b0) begin
            bad++;
            $display("FAIL basic_fs_pulse: fs=%b, required 0", frame_start);
        end
        wait_grant(4'b0010, "basic_g1");
        repeat (2) @(negedge clock);
        done = 4'b0010; d = cyc;
        exp_q.push_back('{4'b1000, d + 3});
        @(negedge clock);
        done = '0;
        total++;
        if (grant !== 4'b0000 || active_id !== 2'd2) begin
            bad++;
            $display("FAIL basic_release: grant=%b id=%0d, required 0000 2", grant, active_id);
        end
        wait_grant(4'b1000, "basic_g3");
        done = 4'b1000;
        @(negedge clock);
        done = '0;
        total++;
        if (grant !== 4'b0000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_last_release: grant=%b busy=%b, required 0000 1", grant, busy);
        end
        @(negedge clock);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy_fall: busy=%b, required 0", busy);
        end
        wait_idle("basic");
        $display("test_basic done");
    endtask

    task automatic test_empty;
        int nb = 0, nt = 0, nf = 0;
        req = '0; tick = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            tick = 1'b0;
            if (busy) nb++;
            if (timeout) nt++;
            if (frame_start) nf++;
        end
        total++;
        if (nb != 5 || nt != 0 || nf != 1) begin
            bad++;
            $display("FAIL empty_frame: busy_cycles=%0d timeouts=%0d starts=%0d, required 5 0 1", nb, nt, nf);
        end
        wait_idle("empty");
        $display("test_empty done");
    endtask

    task automatic test_timeout;
        int t0, hi = 0, nt = 0, tc = -1, lb = -1;
        req = 4'b0001; tick = 1'b1; t0 = cyc;
        exp_q.push_back('{4'b0001, t0 + 2});
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            tick = 1'b0; req = '0;
            if (grant[0]) hi++;
            if (timeout) begin nt++; tc = cyc; end
            if (busy) lb = cyc;
        end
        total++;
        if (hi != TO) begin
            bad++;
            $display("FAIL timeout_len: grant high %0d cycles, required %0d", hi, TO);
        end
        total++;
        if (nt != 1 || tc != t0 + 10) begin
            bad++;
            $display("FAIL timeout_pulse: %0d pulses at cycle %0d, required 1 at %0d", nt, tc, t0 + 10);
        end
        total++;
        if (lb != t0 + 13) begin
            bad++;
            $display("FAIL timeout_busy_fall: last busy cycle %0d, required %0d", lb, t0 + 13);
        end
        wait_idle("timeout");
        $display("test_timeout done");
    endtask

    task automatic test_overrun;
        int t0;
        req = 4'b0100; tick = 1'b1; t0 = cyc;
        exp_q.push_back('{4'b0100, t0 + 4});
        @(negedge clock);
        tick = 1'b0; req = '0;
        wait_grant(4'b0100, "ovr_grant");
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        total++;
        if (overrun !== 1'b1 || overrun_count !== 8'd1 || grant !== 4'b0100) begin
            bad++;
            $display("FAIL overrun_once: ov=%b cnt=%0d grant=%b, required 1 1 0100", overrun, overrun_count, grant);
        end
        @(negedge clock);
        total++;
        if (overrun !== 1'b0 || grant !== 4'b0100) begin
            bad++;
            $display("FAIL overrun_pulse: ov=%b grant=%b, required 0 0100", overrun, grant);
        end
        done = 4'b0100;
        @(negedge clock);
        done = '0;
        wait_idle("overrun");
        // Continuous ticks over empty frames: four rejected ticks per frame.
        tick = 1'b1;
        repeat (400) @(negedge clock);
        tick = 1'b0;
        wait_idle("overrun_sat");
        total++;
        if (overrun_count !== 8'd255) begin
            bad++;
            $display("FAIL overrun_saturate: count=%0d, required 255", overrun_count);
        end
        $display("test_overrun done");
    endtask

    task automatic test_done_ignore;
        int t0;
        req = 4'b0010; tick = 1'b1; t0 = cyc;
        exp_q.push_back('{4'b0010, t0 + 3});
        @(negedge clock);
        tick = 1'b0; req = 4'b1101;
        wait_grant(4'b0010, "ign_grant");
        done = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            total++;
            if (grant !== 4'b0010) begin
                bad++;
                $display("FAIL done_ignored: grant=%b, required 0010", grant);
            end
        end
        done = 4'b0010;
        @(negedge clock);
        done = '0;
        wait_idle("ignore");
        req = '0;
        $display("test_done_ignore done");
    endtask

    task automatic test_reset_mid;
        int t0;
        req = 4'b0001; tick = 1'b1; t0 = cyc;
        exp_q.push_back('{4'b0001, t0 + 2});
        @(negedge clock);
        tick = 1'b0; req = '0;
        wait_grant(4'b0001, "rst_grant");
        reset = 1'b1; tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        total++;
        if (grant !== '0 || busy !== 1'b0 || active_id !== 2'd0 || dut.pending_reg !== '0 ||
            overrun_count !== 8'd0 || overrun !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: grant=%b busy=%b id=%0d pend=%b cnt=%0d ov=%b to=%b, required all 0",
                     grant, busy, active_id, dut.pending_reg, overrun_count, overrun, timeout);
        end
        reset = 1'b0;
        @(negedge clock);
        req = 4'b1000; tick = 1'b1; t0 = cyc;
        exp_q.push_back('{4'b1000, t0 + 5});
        @(negedge clock);
        tick = 1'b0; req = '0;
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL reset_restart: fs=%b, required 1", frame_start);
        end
        wait_grant(4'b1000, "rst_g3");
        done = 4'b1000;
        @(negedge clock);
        done = '0;
        wait_idle("reset_mid");
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_timeout();
        test_overrun();
        test_done_ignore();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
